// File: rtl/neighbor_edge_reader.sv
// Neighbour edge reader: turns queued neighbour words into relative edges
// (dx, dy, dt) against a latched centre event, with a 2-entry output buffer.
module neighbor_edge_reader #(
    parameter int MAX_DEGREE = 16,
    parameter int WIDTH      = 48,
    parameter int CNT_W      = $clog2(MAX_DEGREE) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctr_valid,
    output logic              ctr_ready,
    input  logic [7:0]        ctr_x,
    input  logic [7:0]        ctr_y,
    input  logic [31:0]       ctr_t,
    input  logic [CNT_W-1:0]  nbr_cnt,
    output logic              fifo_rd_en,
    input  logic [WIDTH-1:0]  fifo_dout,
    input  logic              fifo_empty,
    output logic              edge_valid,
    input  logic              edge_ready,
    output logic [8:0]        edge_dx,
    output logic [8:0]        edge_dy,
    output logic [31:0]       edge_dt,
    output logic              edge_last,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DEGREE);

    state_t           state;
    logic [7:0]       cx;
    logic [7:0]       cy;
    logic [31:0]      ct;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] received;
    logic             inflight;

    logic             sk_valid;
    logic             sk_last;
    logic [8:0]       sk_dx;
    logic [8:0]       sk_dy;
    logic [31:0]      sk_dt;

    logic             hs;
    logic             pop;
    logic [1:0]       occ;
    logic [8:0]       arr_dx;
    logic [8:0]       arr_dy;
    logic [31:0]      arr_dt;
    logic             arr_last;

    assign hs  = ctr_valid && ctr_ready;
    assign pop = edge_valid && edge_ready;

    // Occupancy net of the entry leaving this cycle keeps one edge per cycle.
    assign occ = 2'(edge_valid) + 2'(sk_valid) + 2'(inflight) - 2'(pop);

    // Request/handshake signals are pure functions of state and FIFO flags.
    always_comb begin
        ctr_ready  = !rst && (state == IDLE);
        fifo_rd_en = !rst && (state == RUN) && !fifo_empty
                     && (issued < remaining) && (occ < 2'd2);
    end

    // Edge geometry of the word returned by last cycle's read.
    always_comb begin
        arr_dx   = {1'b0, fifo_dout[47:40]} - {1'b0, cx};
        arr_dy   = {1'b0, fifo_dout[39:32]} - {1'b0, cy};
        arr_dt   = ct - fifo_dout[31:0];
        arr_last = (received + CNT_W'(1)) == remaining;
    end

    // Control FSM: latch centre, count issued reads, pulse done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            cx        <= '0;
            cy        <= '0;
            ct        <= '0;
            remaining <= '0;
            issued    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        cx        <= ctr_x;
                        cy        <= ctr_y;
                        ct        <= ctr_t;
                        remaining <= (nbr_cnt > MAX_CNT) ? MAX_CNT : nbr_cnt;
                        issued    <= '0;
                        if (nbr_cnt == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (fifo_rd_en)
                        issued <= issued + CNT_W'(1);
                    if (pop && edge_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry buffer: head drives edge_* directly, skid entry behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= 1'b0;
            received   <= '0;
            edge_valid <= 1'b0;
            edge_last  <= 1'b0;
            edge_dx    <= '0;
            edge_dy    <= '0;
            edge_dt    <= '0;
            sk_valid   <= 1'b0;
            sk_last    <= 1'b0;
            sk_dx      <= '0;
            sk_dy      <= '0;
            sk_dt      <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (hs)
                received <= '0;
            else if (inflight)
                received <= received + CNT_W'(1);
            if (pop || !edge_valid) begin
                if (sk_valid) begin
                    edge_valid <= 1'b1;
                    edge_last  <= sk_last;
                    edge_dx    <= sk_dx;
                    edge_dy    <= sk_dy;
                    edge_dt    <= sk_dt;
                    sk_valid   <= inflight;
                    if (inflight) begin
                        sk_last <= arr_last;
                        sk_dx   <= arr_dx;
                        sk_dy   <= arr_dy;
                        sk_dt   <= arr_dt;
                    end
                end else begin
                    edge_valid <= inflight;
                    edge_last  <= inflight && arr_last;
                    if (inflight) begin
                        edge_dx <= arr_dx;
                        edge_dy <= arr_dy;
                        edge_dt <= arr_dt;
                    end
                end
            end else if (inflight) begin
                sk_valid <= 1'b1;
                sk_last  <= arr_last;
                sk_dx    <= arr_dx;
                sk_dy    <= arr_dy;
                sk_dt    <= arr_dt;
            end
        end
    end

endmodule

// File: tb/tb_neighbor_edge_reader.sv
// Bench for neighbor_edge_reader: FIFO model, edge scoreboard built from
// the arithmetic definition of an edge, and directed event scenarios.
module tb_neighbor_edge_reader;

    localparam int MAXD = 16;
    localparam int W    = 48;
    localparam int CW   = $clog2(MAXD) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctr_valid = 1'b0;
    logic          ctr_ready;
    logic [7:0]    ctr_x = '0;
    logic [7:0]    ctr_y = '0;
    logic [31:0]   ctr_t = '0;
    logic [CW-1:0] nbr_cnt = '0;
    logic          fifo_rd_en;
    logic [W-1:0]  fifo_dout = '0;
    logic          fifo_empty;
    logic          edge_valid;
    logic          edge_ready = 1'b1;
    logic [8:0]    edge_dx;
    logic [8:0]    edge_dy;
    logic [31:0]   edge_dt;
    logic          edge_last;
    logic          done;

    neighbor_edge_reader #(.MAX_DEGREE(MAXD), .WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .ctr_valid(ctr_valid), .ctr_ready(ctr_ready),
        .ctr_x(ctr_x), .ctr_y(ctr_y), .ctr_t(ctr_t), .nbr_cnt(nbr_cnt),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .edge_valid(edge_valid), .edge_ready(edge_ready),
        .edge_dx(edge_dx), .edge_dy(edge_dy), .edge_dt(edge_dt),
        .edge_last(edge_last), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [8:0] dx;
        logic signed [8:0] dy;
        logic [31:0]       dt;
        logic              last;
    } edge_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // FIFO model: standard-mode, data appears the cycle after rd_en.
    logic [W-1:0] fq[$];
    int           fq_len = 0;
    logic         force_empty = 1'b0;
    assign fifo_empty = force_empty || (fq_len == 0);

    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() > 0) begin
            fifo_dout <= fq.pop_front();
            fq_len    <= fq_len - 1;
        end
    end

    // Downstream ready pattern, consumed only on cycles with a valid edge.
    logic rdy_pat[$];
    always @(posedge clk) begin
        #1;
        if (rst)
            edge_ready = 1'b1;
        else if (edge_valid && rdy_pat.size() > 0)
            edge_ready = rdy_pat.pop_front();
        else if (rdy_pat.size() == 0)
            edge_ready = 1'b1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    edge_t exp_q[$];
    edge_t log_q[$];
    int    hs_cyc = -1;
    int    first_rd_cyc = -1;
    int    first_ev_cyc = -1;
    int    done_due = -1;
    int    ahead = 0;
    int    ev_edges = 0;
    int    ev_reads = 0;
    logic  prev_stall = 1'b0;
    logic [51:0] prev_vec = '0;

    // Scoreboard: every cycle the outputs mean something, check them.
    always @(negedge clk) begin
        edge_t e;
        if (rst) begin
            exp_q.delete();
            done_due   = -1;
            ahead      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_when_stalled",
                    {edge_valid, edge_dx, edge_dy, edge_dt, edge_last},
                    prev_vec);
            if (ctr_valid && ctr_ready) begin
                hs_cyc       = cyc;
                first_rd_cyc = -1;
                first_ev_cyc = -1;
                ev_edges     = 0;
                ev_reads     = 0;
                log_q.delete();
                if (nbr_cnt == 0)
                    done_due = cyc + 1;
            end
            if (fifo_rd_en) begin
                chk("rd_en_while_empty", fifo_empty, 0);
                ev_reads++;
                if (first_rd_cyc < 0)
                    first_rd_cyc = cyc;
            end
            if (edge_valid && first_ev_cyc < 0)
                first_ev_cyc = cyc;
            ahead += int'(fifo_rd_en);
            if (edge_valid && edge_ready) begin
                ahead--;
                ev_edges++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_edge", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("edge_dx", $signed(edge_dx), e.dx);
                    chk("edge_dy", $signed(edge_dy), e.dy);
                    chk("edge_dt", edge_dt, e.dt);
                    chk("edge_last", edge_last, e.last);
                    if (e.last)
                        done_due = cyc + 1;
                end
                e.dx = $signed(edge_dx);
                e.dy = $signed(edge_dy);
                e.dt = edge_dt;
                e.last = edge_last;
                log_q.push_back(e);
            end
            if (fifo_rd_en)
                chk("popped_ahead_le2", ahead <= 2, 1);
            if (done || cyc == done_due)
                chk("done_timing", done, cyc == done_due);
            prev_stall = edge_valid && !edge_ready;
            prev_vec = {edge_valid, edge_dx, edge_dy, edge_dt, edge_last};
        end
    end

    function automatic logic [W-1:0] wd(input int x, input int y,
                                        input logic [31:0] t);
        return {8'(x), 8'(y), t};
    endfunction

    logic [W-1:0] wq[$];

    // Queue words, build expected edges from the definition, offer centre.
    task automatic ev_start(input int x, input int y, input logic [31:0] t,
                            input int cnt);
        int n;
        edge_t e;
        @(posedge clk);
        #1;
        n = (cnt > MAXD) ? MAXD : cnt;
        for (int i = 0; i < wq.size(); i++) begin
            fq.push_back(wq[i]);
            if (i < n) begin
                e.dx = 9'(int'(wq[i][47:40]) - x);
                e.dy = 9'(int'(wq[i][39:32]) - y);
                e.dt = t - wq[i][31:0];
                e.last = (i == n - 1);
                exp_q.push_back(e);
            end
        end
        fq_len    = fq.size();
        ctr_x     = 8'(x);
        ctr_y     = 8'(y);
        ctr_t     = t;
        nbr_cnt   = CW'(cnt);
        ctr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ctr_ready) break;
        end
        chk("ctr_handshake", ctr_ready, 1);
        @(posedge clk);
        #1;
        ctr_valid = 1'b0;
    endtask

    task automatic ev_wait_done(input string tag);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_all_edges"}, exp_q.size(), 0);
        @(negedge clk);
        chk({tag, "_ready_back"}, ctr_ready, 1);
    endtask

    task automatic wait_edges(input int k);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ev_edges >= k) break;
        end
        chk("edges_reached", ev_edges >= k, 1);
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctr_ready", ctr_ready, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_edge_valid", edge_valid, 0);
        chk("rst_edge_last", edge_last, 0);
        chk("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", ctr_ready, 1);

        // Three-neighbour reference event with latency pinning.
        wq = '{wd(12, 9, 0), wd(10, 10, 1), wd(3, 20, 65534)};
        ev_start(10, 10, 65536, 3);
        ev_wait_done("t1");
        chk("t1_rd_latency", first_rd_cyc - hs_cyc, 1);
        chk("t1_ev_latency", first_ev_cyc - hs_cyc, 3);
        chk("t1_edges", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("t1_e0_dx", log_q[0].dx, 2);
            chk("t1_e0_dy", log_q[0].dy, -1);
            chk("t1_e0_dt", log_q[0].dt, 65536);
            chk("t1_e1_dt", log_q[1].dt, 65535);
            chk("t1_e2_dx", log_q[2].dx, -7);
            chk("t1_e2_dy", log_q[2].dy, 10);
            chk("t1_e2_dt", log_q[2].dt, 2);
            chk("t1_e2_last", log_q[2].last, 1);
        end

        // Zero neighbours: straight to done, no reads, no edges.
        wq.delete();
        ev_start(1, 2, 3, 0);
        ev_wait_done("t2");
        chk("t2_done_cycle", done_due - hs_cyc, 1);
        chk("t2_reads", ev_reads, 0);
        chk("t2_edges", ev_edges, 0);

        // Back-pressure 1-0-0-1 over four edges.
        wq = '{wd(5, 5, 1), wd(6, 4, 2), wd(7, 3, 3), wd(8, 2, 4)};
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ev_start(6, 6, 100, 4);
        ev_wait_done("t3");
        chk("t3_edges", ev_edges, 4);
        chk("t3_reads", ev_reads, 4);

        // FIFO runs dry mid-event for five cycles.
        wq = '{wd(1, 1, 10), wd(2, 2, 11), wd(3, 3, 12),
               wd(4, 4, 13), wd(5, 5, 14), wd(6, 6, 15)};
        ev_start(0, 0, 20, 6);
        wait_edges(1);
        @(posedge clk);
        #1;
        force_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_rd_en_stalled", fifo_rd_en, 0);
        end
        @(posedge clk);
        #1;
        force_empty = 1'b0;
        ev_wait_done("t4");
        chk("t4_edges", ev_edges, 6);

        // Wrap-around timestamp and largest negative x offset.
        wq = '{wd(0, 7, 32'hFFFF_FFFE)};
        ev_start(255, 7, 5, 1);
        ev_wait_done("t5");
        if (log_q.size() == 1) begin
            chk("t5_dt_wrap", log_q[0].dt, 7);
            chk("t5_dx_min", log_q[0].dx, -255);
        end else begin
            chk("t5_edges", log_q.size(), 1);
        end

        // Reset after the second of five edges.
        wq = '{wd(9, 9, 1), wd(8, 8, 2), wd(7, 7, 3),
               wd(6, 6, 4), wd(5, 5, 5)};
        ev_start(4, 4, 50, 5);
        wait_edges(2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        fq.delete();
        fq_len = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_edge_valid", edge_valid, 0);
        chk("t6_edge_last", edge_last, 0);
        chk("t6_rd_en", fifo_rd_en, 0);
        chk("t6_ready", ctr_ready, 1);
        ev_reads = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_no_done", done, 0);
        end
        chk("t6_no_reads", ev_reads, 0);

        // Next centre after reset, with a count above MAX_DEGREE.
        wq.delete();
        for (int i = 0; i < 20; i++)
            wq.push_back(wd(i * 7, 200 - i, 32'(i * 3)));
        ev_start(100, 100, 1000, 20);
        ev_wait_done("t7");
        chk("t7_clamped_edges", ev_edges, MAXD);
        chk("t7_clamped_reads", ev_reads, MAXD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/neighbor_edge_reader.md
NEIGHBOR_EDGE_READER -- requirements
Module: neighbor_edge_reader

Parameters
REQ-001 SHALL: MAX_DEGREE, default 16, maximum number of neighbours per centre event.
REQ-002 SHALL: WIDTH, default 48, neighbour FIFO word width; word = {x[47:40], y[39:32], t[31:0]}.
REQ-003 SHALL: CNT_W, default $clog2(MAX_DEGREE)+1, neighbour-count width.

Interface
REQ-004 SHALL: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL: ctr_valid  in  1  centre event and count offered.
REQ-007 SHALL: ctr_ready  out  1  centre accepted when ctr_valid&&ctr_ready.
REQ-008 SHALL: ctr_x  in  8  centre x.
REQ-009 SHALL: ctr_y  in  8  centre y.
REQ-010 SHALL: ctr_t  in  32  centre timestamp (t_now).
REQ-011 SHALL: nbr_cnt  in  CNT_W  neighbour words queued in FIFO for this centre.
REQ-012 SHALL: fifo_rd_en  out  1  pop global_neighbor_buffer FIFO (standard mode, dout valid 1 cycle after rd_en).
REQ-013 SHALL: fifo_dout  in  WIDTH  FIFO read data.
REQ-014 SHALL: fifo_empty  in  1  FIFO empty flag.
REQ-015 SHALL: edge_valid  out  1  edge available.
REQ-016 SHALL: edge_ready  in  1  downstream accepts edge.
REQ-017 SHALL: edge_dx  out  9  signed nbr.x - ctr.x.
REQ-018 SHALL: edge_dy  out  9  signed nbr.y - ctr.y.
REQ-019 SHALL: edge_dt  out  32  ctr.t - nbr.t modulo 2^32.
REQ-020 SHALL: edge_last  out  1  marks final edge of current centre.
REQ-021 SHALL: done  out  1  one-cycle pulse when centre fully processed.

Function
REQ-022 SHALL: states IDLE, RUN, DONE; ctr_ready=1 only in IDLE.
REQ-023 SHALL: on centre handshake latch ctr_x/y/t, remaining=min(nbr_cnt, MAX_DEGREE); nbr_cnt=0 -> DONE directly, no reads, no edges.
REQ-024 SHALL: RUN: fifo_rd_en=1 iff !fifo_empty && issued<remaining && (buffer occupancy + in-flight reads) < 2.
REQ-025 SHALL: never assert fifo_rd_en while fifo_empty=1 or outside RUN.
REQ-026 SHALL: returned words captured into a 2-entry output buffer; edge_* driven from buffer head, registered.
REQ-027 SHALL: latency: handshake cycle 0, first fifo_rd_en cycle 1, first edge_valid cycle 3 (FIFO non-empty).
REQ-028 SHALL: sustained throughput one edge/cycle with FIFO non-empty and edge_ready=1.
REQ-029 SHALL: edge_* stable while edge_valid&&!edge_ready; no edge dropped or duplicated.
REQ-030 SHALL: edge_dx/dy = {1'b0,n}-{1'b0,c} in 9-bit two's complement; edge_dt wraps (ctr_t=5, nbr_t=0xFFFFFFFE -> 7).
REQ-031 SHALL: edge_last=1 exactly on the remaining-th edge; its handshake moves RUN->DONE.
REQ-032 SHALL: DONE lasts one cycle with done=1, then IDLE; ctr_valid during RUN/DONE ignored.
REQ-033 SHALL: FIFO empty mid-event stalls reads without timeout; resumes when non-empty.

Reset
REQ-034 SHALL: rst=1 -> state IDLE, counters and buffer cleared; ctr_ready=0 during rst, 1 first cycle after; fifo_rd_en, edge_valid, edge_last, done all 0.
REQ-035 SHALL: reset mid-event abandons the event: popped words discarded, no done pulse, no further reads.

Verification
REQ-036 SHALL: ctr (x=10,y=10,t=65536), nbr_cnt=3, FIFO {(12,9,0),(10,10,1),(3,20,65534)}, edge_ready=1 -> edges dx/dy/dt (2,-1,65536),(0,0,65535),(-7,10,2), last on third, done one cycle later.
REQ-037 SHALL: nbr_cnt=0 -> no fifo_rd_en, no edge_valid, done pulse cycle 1, ctr_ready back to 1.
REQ-038 SHALL: edge_ready toggled 1-0-0-1 during 4-edge event -> outputs held when stalled, exactly 4 edges in order, at most 2 words popped ahead.
REQ-039 SHALL: fifo_empty=1 for 5 cycles mid-event -> fifo_rd_en stays 0, resumes, all edges delivered.
REQ-040 SHALL: ctr_t=5, nbr_t=0xFFFFFFFE, x=0 vs ctr_x=255 -> edge_dt=7, edge_dx=-255.
REQ-041 SHALL: rst asserted after 2nd edge of 5-edge event -> outputs zero next cycle, no done, next centre processed normally.
